// File: rtl/clarvi_part_regfile.sv
// rtl/clarvi_part_regfile.sv - part-serial integer register file with post-reset clear sequencer
// Banked per part so a part write never needs read-modify-write; reads are registered with write-first forwarding.

module clarvi_part_regfile #(
   parameter int XLEN      = 64,
   parameter int PART_W    = 16,
   parameter int NREGS     = 32,
   parameter int DEBUG_REG = 28,
   localparam int PARTS    = XLEN / PART_W,
   localparam int PW       = $clog2(PARTS),
   localparam int RW       = $clog2(NREGS)
) (
   input  logic              clock,
   input  logic              reset,
   output logic              ready,
   input  logic [PW-1:0]     fetch_part,
   input  logic              rs2_part_override,
   input  logic [RW-1:0]     fetch_register_1,
   input  logic [RW-1:0]     fetch_register_2,
   input  logic              write_enable,
   input  logic [RW-1:0]     write_register,
   input  logic [PW-1:0]     write_part,
   input  logic [PART_W-1:0] data_in,
   output logic [PART_W-1:0] data_out_1,
   output logic [PART_W-1:0] data_out_2,
   output logic [XLEN-1:0]   debug_value
);

   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [RW:0]   LAST_IDX = (RW+1)'(NREGS - 1);
   localparam logic [RW-1:0] DBG_IDX  = RW'(DEBUG_REG);

   state_t            state;
   logic [RW:0]       idx;
   logic [PART_W-1:0] mem [PARTS][NREGS];

   logic              write_ok;
   logic [PW-1:0]     part_2;
   logic [PART_W-1:0] read_1;
   logic [PART_W-1:0] read_2;

   always_comb begin
      write_ok = ready && write_enable && (write_register != '0);
      part_2   = rs2_part_override ? '0 : fetch_part;

      read_1 = mem[fetch_part][fetch_register_1];
      if (write_ok && write_register == fetch_register_1 && write_part == fetch_part)
         read_1 = data_in;
      if (fetch_register_1 == '0)
         read_1 = '0;

      read_2 = mem[part_2][fetch_register_2];
      if (write_ok && write_register == fetch_register_2 && write_part == part_2)
         read_2 = data_in;
      if (fetch_register_2 == '0)
         read_2 = '0;
   end

   // Banks carry no reset of their own: the clear sequence zeroes them row by row.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int p = 0; p < PARTS; p++) begin
            if (state == CLEAR)
               mem[p][idx[RW-1:0]] <= '0;
            else if (write_ok && write_part == PW'(p))
               mem[p][write_register] <= data_in;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= CLEAR;
         idx         <= '0;
         ready       <= 1'b0;
         data_out_1  <= '0;
         data_out_2  <= '0;
         debug_value <= '0;
      end else begin
         case (state)
            CLEAR: begin
               data_out_1 <= '0;
               data_out_2 <= '0;
               idx        <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               data_out_1 <= read_1;
               data_out_2 <= read_2;
               // write_ok already excludes register 0, so DEBUG_REG = 0 leaves the shadow at 0.
               for (int p = 0; p < PARTS; p++) begin
                  if (write_ok && write_register == DBG_IDX && write_part == PW'(p))
                     debug_value[p*PART_W +: PART_W] <= data_in;
               end
            end
            default: begin
               state <= CLEAR;
               idx   <= '0;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clarvi_part_regfile.sv
// tb/tb_clarvi_part_regfile.sv - randomized self-checking bench for clarvi_part_regfile
// Reference keeps whole 64-bit registers and a cycles-since-reset count; reads see this cycle's write first.

module tb_clarvi_part_regfile;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ready;
   logic [1:0]  fetch_part = '0;
   logic        rs2_part_override = 1'b0;
   logic [4:0]  fetch_register_1 = '0;
   logic [4:0]  fetch_register_2 = '0;
   logic        write_enable = 1'b0;
   logic [4:0]  write_register = '0;
   logic [1:0]  write_part = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out_1;
   logic [15:0] data_out_2;
   logic [63:0] debug_value;

   logic        s_ready;
   logic [1:0]  s_part = '0;
   logic [3:0]  s_reg = '0;
   logic [7:0]  s_data = '0;
   logic [7:0]  s_out_1;
   logic [7:0]  s_out_2;
   logic [31:0] s_debug;

   clarvi_part_regfile dut (
      .clock(clock), .reset(reset), .ready(ready),
      .fetch_part(fetch_part), .rs2_part_override(rs2_part_override),
      .fetch_register_1(fetch_register_1), .fetch_register_2(fetch_register_2),
      .write_enable(write_enable), .write_register(write_register),
      .write_part(write_part), .data_in(data_in),
      .data_out_1(data_out_1), .data_out_2(data_out_2), .debug_value(debug_value)
   );

   clarvi_part_regfile #(.XLEN(32), .PART_W(8), .NREGS(16), .DEBUG_REG(5)) dut_small (
      .clock(clock), .reset(reset), .ready(s_ready),
      .fetch_part(s_part), .rs2_part_override(1'b0),
      .fetch_register_1(s_reg), .fetch_register_2(s_reg),
      .write_enable(1'b0), .write_register(s_reg),
      .write_part(s_part), .data_in(s_data),
      .data_out_1(s_out_1), .data_out_2(s_out_2), .debug_value(s_debug)
   );

   always #5 clock = ~clock;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [63:0] regs [32];
   int          since_reset = 0;
   int          hot [8] = '{0, 3, 5, 7, 9, 28, 31, 1};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic we, input logic [4:0] wr, input logic [1:0] wp,
                        input logic [15:0] din, input logic [1:0] fp, input logic ovr,
                        input logic [4:0] r1, input logic [4:0] r2);
      logic [15:0] e1, e2;
      int p2;
      write_enable = we; write_register = wr; write_part = wp; data_in = din;
      fetch_part = fp; rs2_part_override = ovr;
      fetch_register_1 = r1; fetch_register_2 = r2;
      @(posedge clock);
      e1 = '0; e2 = '0;
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] = '0;
         since_reset = 0;
      end else begin
         if (since_reset >= 32) begin
            if (we && wr != 0) regs[wr][int'(wp)*16 +: 16] = din;
            p2 = ovr ? 0 : int'(fp);
            e1 = (r1 == 0) ? 16'h0 : regs[r1][int'(fp)*16 +: 16];
            e2 = (r2 == 0) ? 16'h0 : regs[r2][p2*16 +: 16];
         end
         if (since_reset < 100000) since_reset++;
      end
      #1;
      check("ready", 64'(ready), 64'(since_reset >= 32));
      check("ready_small", 64'(s_ready), 64'(since_reset >= 16));
      check("data_out_1", 64'(data_out_1), 64'(e1));
      check("data_out_2", 64'(data_out_2), 64'(e2));
      check("debug_value", debug_value, regs[28]);
   endtask

   task automatic idle_read(input logic [4:0] r, input logic [1:0] p);
      cycle(1'b0, 5'd0, 2'd0, 16'h0, p, 1'b0, r, r);
   endtask

   initial begin
      reset = 1'b1;
      cycle(1'b0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1'b0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      // clear phase: attempted writes must leave no trace
      for (int i = 0; i < 32; i++)
         cycle(1'b1, 5'd5, 2'd2, 16'hDEAD, 2'd2, 1'b0, 5'd5, 5'd5);
      check("ready_after_clear", 64'(ready), 64'd1);
      idle_read(5'd5, 2'd2);
      check("x5_p2_after_clear", 64'(data_out_1), 64'h0);

      cycle(1'b1, 5'd7, 2'd0, 16'h1111, 0, 0, 0, 0);
      cycle(1'b1, 5'd7, 2'd1, 16'h2222, 0, 0, 0, 0);
      cycle(1'b1, 5'd7, 2'd2, 16'h3333, 0, 0, 0, 0);
      cycle(1'b1, 5'd7, 2'd3, 16'h4444, 0, 0, 0, 0);
      cycle(1'b1, 5'd7, 2'd1, 16'hBEEF, 0, 0, 0, 0);
      idle_read(5'd7, 2'd0); check("x7_p0", 64'(data_out_1), 64'h1111);
      idle_read(5'd7, 2'd1); check("x7_p1", 64'(data_out_1), 64'hBEEF);
      idle_read(5'd7, 2'd2); check("x7_p2", 64'(data_out_2), 64'h3333);
      idle_read(5'd7, 2'd3); check("x7_p3", 64'(data_out_2), 64'h4444);

      cycle(1'b1, 5'd9, 2'd0, 16'h0F0F, 0, 0, 0, 0);
      cycle(1'b1, 5'd9, 2'd3, 16'hA5A5, 2'd3, 1'b1, 5'd9, 5'd9);
      check("x9_fwd_p3", 64'(data_out_1), 64'hA5A5);
      check("x9_ovr_p0", 64'(data_out_2), 64'h0F0F);
      cycle(1'b1, 5'd9, 2'd1, 16'h7777, 2'd1, 1'b0, 5'd9, 5'd9);
      check("x9_both_fwd", 64'({data_out_1, data_out_2}), 64'h7777_7777);

      cycle(1'b1, 5'd0, 2'd0, 16'hFFFF, 2'd0, 1'b0, 5'd0, 5'd0);
      check("x0_fwd_1", 64'(data_out_1), 64'h0);
      idle_read(5'd0, 2'd0);
      check("x0_read_2", 64'(data_out_2), 64'h0);

      cycle(1'b1, 5'd28, 2'd0, 16'h1234, 0, 0, 0, 0);
      cycle(1'b1, 5'd28, 2'd3, 16'hCAFE, 0, 0, 0, 0);
      check("debug_x28", debug_value, 64'hCAFE_0000_0000_1234);

      cycle(1'b1, 5'd3, 2'd0, 16'h5555, 0, 0, 0, 0);
      reset = 1'b1;
      cycle(1'b1, 5'd3, 2'd1, 16'h6666, 0, 0, 5'd3, 5'd3);
      reset = 1'b0;
      for (int i = 0; i < 32; i++) idle_read(5'd3, 2'd0);
      idle_read(5'd3, 2'd0);
      check("x3_after_reset", 64'(data_out_1), 64'h0);
      check("debug_after_reset", debug_value, 64'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [4:0] wr, r1, r2;
         wr = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'(hot[$urandom_range(0, 7)]);
         r1 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'(hot[$urandom_range(0, 7)]);
         r2 = ($urandom_range(0, 1) == 0) ? r1 : 5'(hot[$urandom_range(0, 7)]);
         reset = ($urandom_range(0, 399) == 0);
         cycle(1'($urandom_range(0, 1)), wr, 2'($urandom_range(0, 3)), 16'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), r1, r2);
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/clarvi_part_regfile.md
# clarvi_part_regfile

Parametrised part-serial integer register file for the Clarvi core: holds NREGS registers of XLEN bits, read and written PART_W bits per cycle. Storage is banked per part, so a part write needs no read-modify-write. Reads are synchronous with write-first forwarding. A post-reset clear sequencer zeroes the whole file before the core may issue accesses. Sits between decode/writeback and the part-serial ALU, replacing the fixed 64×16 register file.

## Interface

- XLEN, 64, register width in bits; must be a multiple of PART_W.
- PART_W, 16, bits per access.
- NREGS, 32, register count; power of two, ≥2.
- DEBUG_REG, 28, index mirrored on debug_value.
- Derived: PARTS = XLEN/PART_W (power of two, ≥2); PW = clog2(PARTS); RW = clog2(NREGS).

- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- ready  out  1  high once the clear sequence completes; accesses are honoured only while high.
- fetch_part  in  PW  part index for both read ports.
- rs2_part_override  in  1  when high, port 2 reads part 0 regardless of fetch_part.
- fetch_register_1  in  RW  read port 1 register index.
- fetch_register_2  in  RW  read port 2 register index.
- write_enable  in  1  write strobe.
- write_register  in  RW  write register index.
- write_part  in  PW  part index being written.
- data_in  in  PART_W  write data.
- data_out_1  out  PART_W  port 1 data; registered.
- data_out_2  out  PART_W  port 2 data; registered.
- debug_value  out  XLEN  full contents of register DEBUG_REG; registered.

## Operation

- Storage: PARTS banks, each NREGS × PART_W. Bank p holds bits [p*PART_W +: PART_W] of every register.
- Write (ready high, write_enable high, write_register ≠ 0): bank write_part at index write_register gets data_in. Other parts are untouched. Writes to register 0 are dropped.
- Read port n: address = fetch_register_n. Part = fetch_part, or 0 for port 2 when rs2_part_override is high.
  - Index 0 always returns 0.
  - When the same cycle carries a valid write to the same register and part, the port returns data_in (write-first forwarding).
- debug_value: a shadow register. On every accepted write with write_register == DEBUG_REG, its field write_part takes data_in. It is cleared by reset. If DEBUG_REG is 0, it stays 0.
- State machine, two states:
  - CLEAR: clear counter idx (RW+1 bits). Each cycle, every bank is written 0 at index idx, then idx increments. Moves to RUN after idx = NREGS-1 is written.
    - In CLEAR, write_enable is ignored and data_out_1/2 load 0.
  - RUN: normal operation; ready = 1.
  - Any cycle with reset high forces state CLEAR, idx = 0, and performs no bank write.

## Timing

- Reset values: ready = 0, data_out_1 = 0, data_out_2 = 0, debug_value = 0, state = CLEAR, idx = 0.
- Clear duration:
  - The first cycle with reset low writes index 0.
  - Index k is written k cycles after reset deasserts.
  - ready rises at the edge that writes index NREGS-1, so it is visible NREGS cycles after reset falls.
- Read latency is 1 cycle. Addresses sampled at edge t appear on data_out at t+1, and data_out holds until the next edge.
- Write latency:
  - A write at edge t is visible to reads sampled at edge t through forwarding, and to all later reads.
  - It is visible on debug_value after edge t.
- Simultaneous events:
  - A write and both reads may target the same register and part in one cycle; both ports forward.
  - Different parts of one register in the same cycle: the read returns the stored value.
- Reset mid-operation: any in-flight write in the reset cycle is dropped, and the clear sequence restarts from index 0.
- Reset mid-clear: the counter restarts at 0.

## Test plan

- Reset released at cycle 0 with default parameters → ready low for cycles 0..31 and high from cycle 32. During the clear, reads of x5 part 2 return 0x0000. Writes issued during the clear have no effect afterwards.
- Writes to x7 parts 0..3 of 0x1111, 0x2222, 0x3333, 0x4444, then rewrite part 1 with 0xBEEF → parts read back 0x1111, 0xBEEF, 0x3333, 0x4444.
- Same cycle: write x9 part 3 = 0xA5A5, read port1 x9 part 3, and port2 x9 with rs2_part_override (part 0 previously 0x0F0F) → next cycle data_out_1 = 0xA5A5, data_out_2 = 0x0F0F.
- Write x0 part 0 = 0xFFFF, then read x0 on both ports → 0x0000 on both. The same-cycle write is not forwarded.
- Write x28 parts 0 and 3 with 0x1234 and 0xCAFE → debug_value = 0xCAFE_0000_0000_1234 one edge after the second write.
- Reset asserted one cycle mid-run, after x3 part 0 = 0x5555 → ready drops for 32 cycles, then x3 reads 0x0000 and debug_value = 0. Repeat the clear check with XLEN=32, PART_W=8, NREGS=16: ready appears 16 cycles after reset falls.
